// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the memory-access stage.
// Imported by the MEM stage top and its timeout counter.
package mem_access_unit_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mau_state_e;

  localparam int TIMEOUT_CYCLES = 256;
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

endpackage

// File: rtl/mem_access_unit_timeout_counter.sv
// Saturating wait-cycle counter for the data-memory handshake.
// Flags expiry once the last allowed wait cycle is reached.
module mem_timeout_counter
  import mem_access_unit_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign expired = (count_q == CNT_LAST);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: issues data-memory requests, stalls
// upstream until ack or timeout, and drives the MEM/WB register.
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] mem_instruction,
  input  logic        mem_shouldWriteRegister,
  input  logic [4:0]  mem_registerWriteAddress,
  input  logic        mem_shouldWriteMemoryElseAluOutputToRegister,
  input  logic [31:0] mem_aluOutput,
  input  logic        mem_shouldWriteMemory,
  input  logic [31:0] mem_registerRtOrZero,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall,
  output logic [31:0] wb_instruction,
  output logic        wb_shouldWriteRegister,
  output logic [4:0]  wb_registerWriteAddress,
  output logic [31:0] wb_registerWriteData,
  output logic        bus_error,
  output logic        align_error
);

  mau_state_e state_q;
  logic       expired;
  logic       store;
  logic       load;
  logic       memop;
  logic       aligned;

  // A load with the store bit also set is treated as a store.
  assign store   = mem_shouldWriteMemory;
  assign load    = mem_shouldWriteMemoryElseAluOutputToRegister
                   & ~mem_shouldWriteMemory;
  assign memop   = load | store;
  assign aligned = (mem_aluOutput[1:0] == 2'b00);

  always_comb begin
    stall = 1'b0;
    if (!reset) begin
      unique case (state_q)
        IDLE:    stall = memop & aligned;
        WAIT:    stall = ~dmem_ack & ~expired;
        default: stall = 1'b0;
      endcase
    end
  end

  mem_timeout_counter u_timeout (
    .clock   (clock),
    .reset   (reset),
    .clear   (state_q == IDLE),
    .enable  ((state_q == WAIT) & ~dmem_ack),
    .expired (expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q                 <= IDLE;
      dmem_req                <= 1'b0;
      dmem_we                 <= 1'b0;
      dmem_addr               <= '0;
      dmem_wdata              <= '0;
      wb_instruction          <= '0;
      wb_shouldWriteRegister  <= 1'b0;
      wb_registerWriteAddress <= '0;
      wb_registerWriteData    <= '0;
      bus_error               <= 1'b0;
      align_error             <= 1'b0;
    end else begin
      // Bubble by default; completing paths override below.
      wb_instruction          <= '0;
      wb_shouldWriteRegister  <= 1'b0;
      wb_registerWriteAddress <= '0;
      wb_registerWriteData    <= '0;
      unique case (state_q)
        IDLE: begin
          if (!memop) begin
            wb_instruction          <= mem_instruction;
            wb_shouldWriteRegister  <= mem_shouldWriteRegister;
            wb_registerWriteAddress <= mem_registerWriteAddress;
            wb_registerWriteData    <= mem_aluOutput;
          end else if (aligned) begin
            dmem_req   <= 1'b1;
            dmem_we    <= store;
            dmem_addr  <= mem_aluOutput;
            dmem_wdata <= mem_registerRtOrZero;
            state_q    <= WAIT;
          end else begin
            align_error <= 1'b1;
          end
        end
        WAIT: begin
          if (dmem_ack) begin
            dmem_req                <= 1'b0;
            wb_instruction          <= mem_instruction;
            wb_shouldWriteRegister  <= mem_shouldWriteRegister
                                       & ~store;
            wb_registerWriteAddress <= mem_registerWriteAddress;
            wb_registerWriteData    <= load ? dmem_rdata
                                            : mem_aluOutput;
            state_q                 <= IDLE;
          end else if (expired) begin
            dmem_req  <= 1'b0;
            bus_error <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL: clock  input  1  stage clock, all state updates on rising edge.
REQ-002 SHALL: reset  input  1  synchronous, active-high.
REQ-003 SHALL: mem_instruction  input  32  instruction currently in MEM stage (EX/MEM register output).
REQ-004 SHALL: mem_shouldWriteRegister  input  1  instruction writes register file.
REQ-005 SHALL: mem_registerWriteAddress  input  5  destination register.
REQ-006 SHALL: mem_shouldWriteMemoryElseAluOutputToRegister  input  1  load select: 1 = register data from memory, 0 = from ALU.
REQ-007 SHALL: mem_aluOutput  input  32  effective address (load/store) or ALU result.
REQ-008 SHALL: mem_shouldWriteMemory  input  1  store request.
REQ-009 SHALL: mem_registerRtOrZero  input  32  store data.
REQ-010 SHALL: dmem_req  output  1  data-memory request, registered.
REQ-011 SHALL: dmem_we  output  1  1 = write, registered.
REQ-012 SHALL: dmem_addr / dmem_wdata  output  32 each  address, write data, registered.
REQ-013 SHALL: dmem_rdata  input  32  read data, valid with dmem_ack; dmem_ack  input  1  completion.
REQ-014 SHALL: stall  output  1  combinational; upstream holds EX/MEM contents while high.
REQ-015 SHALL: wb_instruction  output  32;  wb_shouldWriteRegister  output  1;  wb_registerWriteAddress  output  5;  wb_registerWriteData  output  32  (MEM/WB register).
REQ-016 SHALL: bus_error / align_error  output  1 each  sticky fault flags.

Function
REQ-017 SHALL: memop = load | store, load = select bit & !mem_shouldWriteMemory, store = mem_shouldWriteMemory; a load with both bits set is treated as store.
REQ-018 SHALL: FSM states IDLE, WAIT.
REQ-019 SHALL: IDLE, !memop -> capture inputs into wb_* next edge, write data = mem_aluOutput, stall=0, stay IDLE (1-cycle latency).
REQ-020 SHALL: IDLE, memop, mem_aluOutput[1:0]==0 -> stall=1, next edge dmem_req=1, dmem_we=store, dmem_addr=mem_aluOutput, dmem_wdata=mem_registerRtOrZero, wb_shouldWriteRegister=0 (bubble), -> WAIT, timeout counter cleared.
REQ-021 SHALL: IDLE, memop, misaligned -> no request, align_error set, instruction squashed (wb bubble with wb_instruction=0), stall=0, stay IDLE.
REQ-022 SHALL: WAIT, !dmem_ack -> stall=1, dmem_* held stable, wb bubble, counter+1.
REQ-023 SHALL: WAIT, dmem_ack -> stall=0; next edge dmem_req=0, wb_* loaded (write data = dmem_rdata for load, mem_aluOutput for store; wb_shouldWriteRegister = mem_shouldWriteRegister & !store), -> IDLE; minimum memop latency 2 cycles.
REQ-024 SHALL: WAIT, counter == TIMEOUT_CYCLES-1 (255) without ack -> stall=0, dmem_req=0 next edge, bus_error set, wb bubble, -> IDLE; ack on that same cycle wins over timeout.
REQ-025 SHALL: dmem_ack in IDLE ignored.
REQ-026 SHALL: counter 8-bit, saturating, never wraps.
REQ-027 SHALL: fault flags cleared only by reset.

Reset
REQ-028 SHALL: reset forces state IDLE, counter 0, all registered outputs 0 (dmem_*, wb_*, bus_error, align_error) on next edge, including mid-WAIT (request abandoned); stall=0 while reset high.

Structure
REQ-029 SHALL: shared package holds state enum (IDLE, WAIT) and TIMEOUT_CYCLES=256.
REQ-030 SHALL: one sub-module mem_timeout_counter (clear, enable, expired) natural; rest flat.

Verification
REQ-031 SHALL: ALU op addr/result 0x00000010, rd=5 -> next edge wb_registerWriteData=0x10, wb_registerWriteAddress=5, stall never high.
REQ-032 SHALL: load addr 0x100, ack 3 cycles after req with rdata 0xDEADBEEF -> stall high 4 cycles, wb_registerWriteData=0xDEADBEEF, wb_shouldWriteRegister=1.
REQ-033 SHALL: store addr 0x200 data 0x12345678, ack first WAIT cycle -> dmem_we=1, addr/wdata match, latency 2, wb_shouldWriteRegister=0.
REQ-034 SHALL: load addr 0x102 -> dmem_req stays 0, align_error=1, stall 0.
REQ-035 SHALL: load, no ack -> dmem_req drops after 256 WAIT cycles, bus_error=1, stall released.
REQ-036 SHALL: reset asserted mid-WAIT -> next edge dmem_req=0, state IDLE, flags 0.
